// File: rtl/i2c_init_pkg.sv
// Shared types and the default codec table for the I2C init sequencer.
// Build option: I2C_INIT_DELAY_EN adds a 16-bit post-delay field to each table entry.
package i2c_init_pkg;

  localparam int unsigned I2C_TABLE_DEPTH = 8;
  localparam int unsigned I2C_TABLE_IDX_W = $clog2(I2C_TABLE_DEPTH);
  localparam int unsigned I2C_FRAME_W     = 32;
  localparam int unsigned I2C_DELAY_W     = 16;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StGap,
    StDone,
    StError
  } state_e;

  typedef struct packed {
`ifdef I2C_INIT_DELAY_EN
    logic [I2C_DELAY_W-1:0] delay;
`endif
    logic [I2C_FRAME_W-1:0] frame;
  } entry_t;

`ifdef I2C_INIT_DELAY_EN
  // Entry 0 resets the codec; the delay lets it settle before the next write.
  localparam entry_t I2C_DEFAULT_TABLE [I2C_TABLE_DEPTH] = '{
    '{delay: 16'd200, frame: 32'h0034_1E00},
    '{delay: 16'd0,   frame: 32'h0034_0815},
    '{delay: 16'd0,   frame: 32'h0034_0A00},
    '{delay: 16'd0,   frame: 32'h0034_0C00},
    '{delay: 16'd0,   frame: 32'h0034_0E42},
    '{delay: 16'd0,   frame: 32'h0034_1019},
    '{delay: 16'd0,   frame: 32'h0034_1201},
    '{delay: 16'd0,   frame: 32'h0000_0000}
  };
`else
  localparam entry_t I2C_DEFAULT_TABLE [I2C_TABLE_DEPTH] = '{
    '{frame: 32'h0034_1E00},
    '{frame: 32'h0034_0815},
    '{frame: 32'h0034_0A00},
    '{frame: 32'h0034_0C00},
    '{frame: 32'h0034_0E42},
    '{frame: 32'h0034_1019},
    '{frame: 32'h0034_1201},
    '{frame: 32'h0000_0000}
  };
`endif

  function automatic logic [I2C_FRAME_W-1:0] i2c_table_frame(
    input logic [I2C_TABLE_IDX_W-1:0] idx
  );
    return I2C_DEFAULT_TABLE[idx].frame;
  endfunction

`ifdef I2C_INIT_DELAY_EN
  function automatic logic [I2C_DELAY_W-1:0] i2c_table_delay(
    input logic [I2C_TABLE_IDX_W-1:0] idx
  );
    return I2C_DEFAULT_TABLE[idx].delay;
  endfunction
`endif

endpackage

// File: rtl/i2c_init_timer.sv
// Saturating down-counter shared by the gap and timeout phases of the sequencer.
// o_expired is high whenever the count has reached zero.
module i2c_init_timer #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/i2c_init_sequencer.sv
// Table-driven I2C configuration sequencer with NACK retry, timeout and inter-command gap.
// Build option: I2C_INIT_DELAY_EN stretches the gap after a success to the entry's delay field.
module i2c_init_sequencer
  import i2c_init_pkg::*;
#(
  parameter int unsigned N_CMDS         = 7,
  parameter int unsigned DATA_W         = 24,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned IDX_W         = (N_CMDS > 1) ? $clog2(N_CMDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_finished,
  output logic              o_error,
  output logic [IDX_W-1:0]  o_err_idx,
  output logic [DATA_W-1:0] o_cmd_data,
  output logic              o_cmd_start,
  input  logic              i_cmd_done,
  input  logic              i_cmd_nack
);

  localparam int unsigned RTRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
`ifdef I2C_INIT_DELAY_EN
  localparam int unsigned GAP_MAX = (GAP_CYCLES > 65535) ? GAP_CYCLES : 65535;
`else
  localparam int unsigned GAP_MAX = GAP_CYCLES;
`endif
  localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > GAP_MAX) ? TIMEOUT_CYCLES : GAP_MAX;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  state_e              r_state, w_state_next;
  logic [IDX_W-1:0]    r_idx;
  logic [RTRY_W-1:0]   r_retry;
  logic [DATA_W-1:0]   r_cmd_data;

  logic                w_start_ok, w_success, w_fail, w_last, w_can_retry;
  logic                w_tmr_load, w_tmr_tick, w_expired;
  logic [TMR_W-1:0]    w_tmr_val, w_gap_len;

  assign w_start_ok  = i_start && (r_state inside {StIdle, StDone, StError});
  assign w_success   = i_cmd_done && !i_cmd_nack;
  // A completion in the expiry cycle takes priority over the timeout.
  assign w_fail      = i_cmd_done ? i_cmd_nack : w_expired;
  assign w_last      = (r_idx == IDX_W'(N_CMDS - 1));
  assign w_can_retry = (RETRY_MAX != 0) && (r_retry != RTRY_W'(RETRY_MAX));
  assign w_tmr_tick  = (r_state inside {StWait, StGap});

`ifdef I2C_INIT_DELAY_EN
  logic [I2C_DELAY_W-1:0] w_delay;
  assign w_delay = i2c_table_delay(I2C_TABLE_IDX_W'(r_idx));
`endif

  always_comb begin
    w_gap_len = TMR_W'(GAP_CYCLES);
`ifdef I2C_INIT_DELAY_EN
    if (w_success && (TMR_W'(w_delay) > w_gap_len)) begin
      w_gap_len = TMR_W'(w_delay);
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    unique case (r_state)
      StIdle, StError: begin
        if (i_start) w_state_next = StIssue;
      end
      StDone: begin
        w_state_next = i_start ? StIssue : StIdle;
      end
      StIssue: begin
        w_state_next = StWait;
        w_tmr_load   = 1'b1;
        w_tmr_val    = TMR_W'(TIMEOUT_CYCLES - 1);
      end
      StWait: begin
        if (w_success && w_last) begin
          w_state_next = StDone;
        end else if (w_success || (w_fail && w_can_retry)) begin
          w_state_next = (w_gap_len == '0) ? StIssue : StGap;
          w_tmr_load   = 1'b1;
          w_tmr_val    = w_gap_len - 1'b1;
        end else if (w_fail) begin
          w_state_next = StError;
        end
      end
      StGap: begin
        if (w_expired) w_state_next = StIssue;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_busy      = 1'b0;
    o_cmd_start = 1'b0;
    o_finished  = 1'b0;
    o_error     = 1'b0;
    o_err_idx   = '0;
    unique case (r_state)
      StIssue: begin
        o_busy      = 1'b1;
        o_cmd_start = 1'b1;
      end
      StWait, StGap: o_busy = 1'b1;
      StDone:        o_finished = 1'b1;
      StError: begin
        o_error   = 1'b1;
        o_err_idx = r_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx      <= '0;
      r_retry    <= '0;
      r_cmd_data <= '0;
    end else if (w_start_ok) begin
      r_idx      <= '0;
      r_retry    <= '0;
      r_cmd_data <= DATA_W'(i2c_table_frame('0));
    end else if (r_state == StWait) begin
      if (w_success && !w_last) begin
        r_idx      <= r_idx + 1'b1;
        r_retry    <= '0;
        r_cmd_data <= DATA_W'(i2c_table_frame(I2C_TABLE_IDX_W'(r_idx + 1'b1)));
      end else if (!w_success && w_fail && w_can_retry) begin
        r_retry <= r_retry + 1'b1;
      end
    end
  end

  assign o_cmd_data = r_cmd_data;

  i2c_init_timer #(
    .CNT_W(TMR_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_tick     (w_tmr_tick),
    .o_expired  (w_expired)
  );

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer: vector table of transactions plus hand-written
// timeout, gap-0 and reset sequences on a second, retry-free instance.
`timescale 1ns/1ps
module tb_i2c_init_sequencer;

`ifdef I2C_INIT_DELAY_EN
  localparam int E0_GAP   = 200;  // max(4, 200)
  localparam int T_GAP0SP = 204;  // ack at +3, then max(0, 200)
`else
  localparam int E0_GAP   = 4;
  localparam int T_GAP0SP = 4;
`endif
  localparam int SP1 = 11 + E0_GAP;  // ack at +10, one cycle to leave WAIT, then gap
  localparam int SPT = 65 + E0_GAP;  // ack in the timeout-expiry cycle (+64)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, done = 1'b0, nack = 1'b0;
  logic busy, finished, error, cmd_start;
  logic [2:0]  err_idx;
  logic [23:0] cmd_data;
  logic start_t = 1'b0, done_t = 1'b0, nack_t = 1'b0;
  logic busy_t, finished_t, error_t, cmd_start_t;
  logic [2:0]  err_idx_t;
  logic [23:0] cmd_data_t;

  always #5 clk = ~clk;

  i2c_init_sequencer #(
    .N_CMDS(7), .DATA_W(24), .RETRY_MAX(3), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_finished(finished),
    .o_error(error), .o_err_idx(err_idx), .o_cmd_data(cmd_data), .o_cmd_start(cmd_start),
    .i_cmd_done(done), .i_cmd_nack(nack)
  );

  i2c_init_sequencer #(
    .N_CMDS(7), .DATA_W(24), .RETRY_MAX(0), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64)
  ) u_dut_t (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_t), .o_busy(busy_t),
    .o_finished(finished_t), .o_error(error_t), .o_err_idx(err_idx_t),
    .o_cmd_data(cmd_data_t), .o_cmd_start(cmd_start_t), .i_cmd_done(done_t),
    .i_cmd_nack(nack_t)
  );

  typedef struct {
    logic [23:0] data;
    int          ack_after;
    bit          nack;
    int          space;
  } vec_t;

  vec_t vq[$];
  logic [23:0] fr [7] = '{24'h341E00, 24'h340815, 24'h340A00, 24'h340C00,
                          24'h340E42, 24'h341019, 24'h341201};
  int cyc = 0;
  int fin_cnt = 0;
  int n_pass = 0, n_total = 0;
  int last_pulse = 0;
  int np, n, t0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (finished) fin_cnt <= fin_cnt + 1;

  function automatic vec_t mk(logic [23:0] d, int a, bit nk, int s);
    vec_t v;
    v.data = d; v.ack_after = a; v.nack = nk; v.space = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic kick();
    start = 1'b1;
    last_pulse = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic run_vecs(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      int k;
      k = 0;
      while (cmd_start !== 1'b1 && k < 400) begin
        step();
        k++;
      end
      check($sformatf("v%0d pulse_seen", i), {31'b0, cmd_start === 1'b1}, 1);
      if (cmd_start !== 1'b1) return;
      check($sformatf("v%0d cmd_data", i), cmd_data, vq[i].data);
      check($sformatf("v%0d spacing", i), cyc - last_pulse, vq[i].space);
      last_pulse = cyc;
      step();
      check($sformatf("v%0d start_one_cycle", i), cmd_start, 0);
      check($sformatf("v%0d busy_in_wait", i), busy, 1);
      repeat (vq[i].ack_after - 1) step();
      done = 1'b1;
      nack = vq[i].nack;
      step();
      done = 1'b0;
      nack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    // 0..6 happy path
    for (int i = 0; i < 7; i++) vq.push_back(mk(fr[i], 10, 1'b0, (i == 0) ? 1 : (i == 1) ? SP1 : 15));
    // 7..15 retry: entry 2 NACKs twice
    vq.push_back(mk(fr[0], 10, 1'b0, 1));
    vq.push_back(mk(fr[1], 10, 1'b0, SP1));
    vq.push_back(mk(fr[2], 10, 1'b1, 15));
    vq.push_back(mk(fr[2], 10, 1'b1, 15));
    vq.push_back(mk(fr[2], 10, 1'b0, 15));
    for (int i = 3; i < 7; i++) vq.push_back(mk(fr[i], 10, 1'b0, 15));
    // 16..23 exhaustion: entry 4 always NACKs
    vq.push_back(mk(fr[0], 10, 1'b0, 1));
    vq.push_back(mk(fr[1], 10, 1'b0, SP1));
    vq.push_back(mk(fr[2], 10, 1'b0, 15));
    vq.push_back(mk(fr[3], 10, 1'b0, 15));
    for (int i = 0; i < 4; i++) vq.push_back(mk(fr[4], 10, 1'b1, 15));
    // 24..26 done in the timeout-expiry cycle counts as success
    vq.push_back(mk(fr[0], 64, 1'b0, 1));
    vq.push_back(mk(fr[1], 10, 1'b0, SPT));
    vq.push_back(mk(fr[2], 10, 1'b0, 15));

    repeat (2) step();
    check("rst busy", busy, 0);
    check("rst finished", finished, 0);
    check("rst error", error, 0);
    check("rst err_idx", err_idx, 0);
    check("rst cmd_start", cmd_start, 0);
    check("rst cmd_data", cmd_data, 0);
    rst_n = 1'b1;
    repeat (2) step();

    kick();
    run_vecs(0, 7);
    check("happy finished", finished, 1);
    check("happy done busy", busy, 0);
    check("happy error", error, 0);
    step();
    check("finished one cycle", finished, 0);
    check("happy fin_cnt", fin_cnt, 1);

    repeat (3) step();
    kick();
    run_vecs(7, 9);
    check("retry finished", finished, 1);
    step();
    check("retry fin_cnt", fin_cnt, 2);

    repeat (3) step();
    kick();
    run_vecs(16, 8);
    check("exhaust error", error, 1);
    check("exhaust err_idx", err_idx, 4);
    check("exhaust busy", busy, 0);
    np = 0;
    repeat (20) begin
      step();
      np += int'(cmd_start);
    end
    check("exhaust no pulse", np, 0);
    check("exhaust error held", error, 1);
    check("exhaust fin_cnt", fin_cnt, 2);

    kick();
    check("restart clears error", error, 0);
    run_vecs(24, 3);

    // Entry 3: start during WAIT is ignored, then reset mid-transaction.
    n = 0;
    while (cmd_start !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check("e3 data", cmd_data, 24'h340C00);
    check("e3 spacing", cyc - last_pulse, 15);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy start ignored", cmd_start, 0);
    check("busy start data", cmd_data, 24'h340C00);
    check("busy start busy", busy, 1);
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check("async rst busy", busy, 0);
    check("async rst cmd_data", cmd_data, 0);
    check("async rst cmd_start", cmd_start, 0);
    check("async rst error", error, 0);
    step();
    rst_n = 1'b1;
    np = 0;
    repeat (30) begin
      step();
      np += int'(cmd_start);
    end
    check("no pulse after reset", np, 0);
    kick();
    check("restart pulse", cmd_start, 1);
    check("restart data", cmd_data, 24'h341E00);

    // Timeout with no retry, then gap-0 back-to-back issue.
    start_t = 1'b1;
    step();
    start_t = 1'b0;
    check("t pulse", cmd_start_t, 1);
    check("t data0", cmd_data_t, 24'h341E00);
    repeat (64) step();
    check("t busy at expiry", busy_t, 1);
    check("t error at expiry", error_t, 0);
    step();
    check("t error", error_t, 1);
    check("t err_idx", err_idx_t, 0);
    check("t busy", busy_t, 0);
    repeat (5) step();
    check("t error held", error_t, 1);
    start_t = 1'b1;
    step();
    start_t = 1'b0;
    check("t restart pulse", cmd_start_t, 1);
    check("t error cleared", error_t, 0);
    t0 = cyc;
    repeat (3) step();
    done_t = 1'b1;
    step();
    done_t = 1'b0;
    n = 0;
    while (cmd_start_t !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check("t gap spacing", cyc - t0, T_GAP0SP);
    check("t data1", cmd_data_t, 24'h340815);
    repeat (65) step();
    check("t error idx1", error_t, 1);
    check("t err_idx1", err_idx_t, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Parametrised table-driven I2C configuration sequencer. It is the next generation of the fixed seven-write codec initializer.
- It walks N_CMDS entries of DATA_W-bit write frames and hands each one to the existing byte-level I2C controller through a start/done handshake.
- It adds retry on NACK, a per-transaction timeout, a programmable inter-command gap, and error reporting.
- It sits between top-level bring-up logic and the I2C controller.

Parameters:
- N_CMDS, 7, number of table entries issued (1..I2C_TABLE_DEPTH).
- DATA_W, 24, frame width: device address, register address and data.
- RETRY_MAX, 3, re-issues allowed per entry after NACK or timeout (0 = no retry).
- GAP_CYCLES, 16, idle cycles between transactions (0 = back-to-back).
- TIMEOUT_CYCLES, 4096, maximum cycles waiting for i_cmd_done.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  synchronous level; sampled high in IDLE, DONE or ERROR starts the sequence from entry 0.
- o_busy  out  1  high from the cycle after start until DONE or ERROR.
- o_finished  out  1  one-cycle pulse after the last entry is acknowledged.
- o_error  out  1  level; held high from ERROR entry until next start or reset.
- o_err_idx  out  $clog2(N_CMDS)  entry that failed; valid while o_error.
- o_cmd_data  out  DATA_W  frame to the controller; stable from the start pulse until done.
- o_cmd_start  out  1  one-cycle start pulse to the controller.
- i_cmd_done  in  1  controller completion pulse.
- i_cmd_nack  in  1  qualifies i_cmd_done; 1 = slave did not acknowledge.

Behaviour:
- Clock and reset: one clock, i_clk; reset is asynchronous and active-low, i_rst_n.
- Reset values: all outputs 0; state IDLE; idx=0; retry=0; counters 0. Reset mid-transaction aborts immediately; no start pulse is emitted afterwards.
- States: IDLE, ISSUE, WAIT, GAP, DONE, ERROR.
- IDLE / DONE / ERROR to ISSUE: when i_start=1.
  - Clear idx, retry and o_error.
  - Load o_cmd_data = table[0] on the same edge.
- ISSUE:
  - o_cmd_start=1 for exactly one cycle.
  - Go to WAIT; clear the timeout counter.
- WAIT: the timeout counter increments each cycle.
  - i_cmd_done & !i_cmd_nack: success.
    - If idx==N_CMDS-1, go to DONE.
    - Otherwise idx+1, retry=0, load next data, go to GAP.
  - i_cmd_done & i_cmd_nack, or counter reaching TIMEOUT_CYCLES-1 without done: failure.
    - If retry<RETRY_MAX, retry+1, go to GAP; data is unchanged.
    - Otherwise go to ERROR; o_err_idx=idx.
  - Simultaneous done and timeout expiry: done wins and is evaluated normally.
- GAP:
  - Count GAP_CYCLES, then go to ISSUE.
  - With GAP_CYCLES=0, go directly to ISSUE the next cycle.
- DONE:
  - o_finished=1 for one cycle, then go to IDLE.
  - o_busy deasserts in the DONE cycle.
- ERROR:
  - o_error held, o_busy=0.
  - Stay until i_start.
- i_start while busy: ignored.
- i_cmd_done outside WAIT: ignored.
- Latency:
  - Start-to-first-pulse: 1 cycle.
  - Done-to-next-pulse: GAP_CYCLES+1 cycles.
- Widths:
  - idx is $clog2(N_CMDS), minimum 1 bit.
  - retry is $clog2(RETRY_MAX+1).
  - Timeout and gap counters are sized from their parameters and saturate; they never wrap.

Optional Feature:
- Macro: I2C_INIT_DELAY_EN.
- Defined:
  - Each table entry carries an extra 16-bit post-delay field.
  - After a successful transaction, GAP lasts max(GAP_CYCLES, entry delay).
  - Used for the codec reset-settle time.
- Undefined:
  - The delay field is absent from the table type.
  - GAP is always GAP_CYCLES.

Decomposition:
- Package i2c_init_pkg holds:
  - state enum;
  - I2C_TABLE_DEPTH;
  - the entry struct (frame, plus delay under the macro);
  - the default codec table constant: 0x341E00, 0x340815, 0x340A00, 0x340C00, 0x340E42, 0x341019, 0x341201.
- Sub-module i2c_init_timer: shared down-counter used for both gap and timeout, with load, tick and expired signals.

Test Plan:
- Happy path:
  - Stimulus: N_CMDS=7, GAP_CYCLES=4; model always acks after 10 cycles.
  - Response: seven start pulses carrying 0x341E00 through 0x341201 in order; pulse spacing 15 cycles; o_finished pulse once; o_error=0.
- Retry:
  - Stimulus: NACK entry 2 twice, then ack; RETRY_MAX=3.
  - Response: 0x340A00 issued three times, then the sequence completes.
- Exhaustion:
  - Stimulus: entry 4 always NACKs; RETRY_MAX=3.
  - Response: four issues of 0x340E42; o_error=1; o_err_idx=4; no o_finished; o_busy=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=64; model never completes; RETRY_MAX=0.
  - Response: ERROR after 64 WAIT cycles; o_err_idx=0.
- Reset and restart:
  - Stimulus: i_start during WAIT is ignored; assert i_rst_n low mid-entry 3.
  - Response: all outputs 0 and no further pulses; a new start restarts at 0x341E00.
- Tie and delay:
  - Stimulus: done coincides with the timeout-expiry cycle.
  - Response: treated as success.
  - Stimulus: with I2C_INIT_DELAY_EN and entry 0 delay=200.
  - Response: gap after entry 0 is 200 cycles.
